round_sequencer: RTL
====================

// Module: round_sequencer
// PURPOSE
//  Multi-channel, parametrised successor to the single-channel SHA round counter.
//  N_CH independent round counters run from MIN_VAL to MAX_VAL in STEP increments.
//  Each channel has a start/done/ack handshake and a ONESHOT or CONTINUOUS mode.
//  Sits between the miner control FSM and N_CH parallel SHA-256 compression cores.
// PARAMETERS
//  WIDTH    7    counter width; elaboration error if MAX_VAL >= 2**WIDTH
//  MIN_VAL  0    first round index after start / wrap / abort
//  MAX_VAL  64   final round index; elaboration error if MAX_VAL <= MIN_VAL
//  STEP     1    increment per enable; elaboration error if (MAX_VAL-MIN_VAL)%STEP != 0
//  N_CH     2    number of independent channels (>=1)
//  MODE     0    0 = ONESHOT (stop in DONE at MAX_VAL), 1 = CONTINUOUS (wrap forever)
// PORTS
//  clk      in   1           system clock, rising edge
//  rst      in   1           asynchronous, active-high reset
//  start    in   N_CH        per-channel start request (level sampled each cycle)
//  enable   in   N_CH        per-channel advance-one-step
//  abort    in   N_CH        per-channel return to IDLE
//  ack      in   N_CH        per-channel done acknowledge
//  err_clr  in   1           clears all sticky err bits
//  count    out  N_CH*WIDTH  packed counts; channel i at [i*WIDTH +: WIDTH]
//  busy     out  N_CH        channel in RUN
//  last     out  N_CH        combinational: RUN && count==MAX_VAL
//  wrap     out  N_CH        1-cycle pulse on a CONTINUOUS wrap MAX_VAL->MIN_VAL
//  done     out  N_CH        channel in DONE (held until ack)
//  err      out  N_CH        sticky: a start arrived while in RUN, or in DONE without ack
// BEHAVIOUR
//  Reset: all channels IDLE. count=MIN_VAL; busy, wrap, done, err = 0.
//  Per-channel states: IDLE, RUN, DONE. Channels never interact.
//  Input priority each cycle: abort > start/ack > enable.
//  IDLE: start -> RUN and count<=MIN_VAL; enable is ignored.
//  RUN, enable, count<MAX_VAL: count<=count+STEP.
//  RUN, enable, count==MAX_VAL:
//    ONESHOT    -> DONE; count holds MAX_VAL.
//    CONTINUOUS -> stay in RUN; count<=MIN_VAL; wrap=1 the next cycle.
//  RUN, enable low: count holds.
//  RUN, start: ignored; err<=1.
//  DONE: done=1; count holds MAX_VAL; enable ignored.
//    ack alone        -> IDLE, count<=MIN_VAL.
//    ack and start    -> RUN, count<=MIN_VAL (back-to-back, no idle cycle).
//    start without ack -> ignored; err<=1.
//  abort in any state -> IDLE, count<=MIN_VAL, wrap=0 next cycle. Abort does not touch err.
//  err_clr: err<=0, unless a new error event occurs the same cycle (set wins).
//  Latency: every state and count change is visible 1 cycle after the sampling edge.
//    busy/done/wrap are registered.
//  Arithmetic: unsigned WIDTH bits; the count never exceeds MAX_VAL, so no overflow.
//  Reset mid-operation: immediate asynchronous return to reset values; no pending state is kept.
// STRUCTURE
//  Package round_seq_pkg:
//    typedef enum logic [1:0] {RS_IDLE, RS_RUN, RS_DONE} rs_state_t
//    localparam MODE_ONESHOT=0, MODE_CONTINUOUS=1
//  Sub-module round_seq_ch: one channel (FSM + counter + err).
//    Same parameters minus N_CH; scalar ports.
//  Top: generate loop of N_CH round_seq_ch instances; packs count; fans out err_clr.
//  Parameter legality is checked with elaboration-time assertions in the top.
// TESTING
//  1. Reset, defaults, ONESHOT: start[0], then 64 enables.
//     -> count0 steps 0..64; last0=1 at 64; 65th enable -> done0=1, busy0=0.
//     -> ack0 -> IDLE, count0=0.
//  2. CONTINUOUS, MIN_VAL=0, MAX_VAL=8, STEP=2: start, 5 enables.
//     -> count 0,2,4,6,8,0; wrap=1 only in the cycle count returns to 0.
//  3. Back-to-back: in DONE, assert start+ack together.
//     -> next cycle busy=1, count=MIN_VAL, done=0, err=0.
//  4. Errors: start in RUN -> err=1 and count unaffected.
//     err_clr together with start-in-DONE-no-ack -> err stays 1.
//     err_clr alone -> err=0.
//  5. Abort/reset: abort with start+enable at count=30 -> IDLE, count=MIN_VAL.
//     rst asserted mid-RUN, between edges -> all outputs at reset values immediately.
//  6. Independence (N_CH=4): random per-channel stimulus checked against a scoreboard model.
//     -> no cross-channel effect; channel 2 start-while-RUN sets err[2] only.

Source files
------------

// File: rtl/round_seq_pkg.sv
// Shared types and mode constants for the multi-channel round sequencer.
// Imported by the channel and top modules.
package round_seq_pkg;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_RUN,
        RS_DONE
    } rs_state_t;

    localparam int MODE_ONESHOT    = 0;
    localparam int MODE_CONTINUOUS = 1;

endpackage

// File: rtl/round_seq_if.sv
// Control/status bundle between the miner control FSM (master)
// and the round sequencer (slave). Counts are packed per channel.
interface round_seq_if #(
    parameter int N_CH  = 2,
    parameter int WIDTH = 7
);
    logic [N_CH-1:0]       start;
    logic [N_CH-1:0]       enable;
    logic [N_CH-1:0]       abort;
    logic [N_CH-1:0]       ack;
    logic                  err_clr;
    logic [N_CH*WIDTH-1:0] count;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       last;
    logic [N_CH-1:0]       wrap;
    logic [N_CH-1:0]       done;
    logic [N_CH-1:0]       err;

    modport master (
        output start, enable, abort, ack, err_clr,
        input  count, busy, last, wrap, done, err
    );

    modport slave (
        input  start, enable, abort, ack, err_clr,
        output count, busy, last, wrap, done, err
    );
endinterface

// File: rtl/round_seq_ch.sv
// One round-counter channel: IDLE/RUN/DONE FSM, stepped counter, sticky err.
// Ports: clk, rst, start/enable/abort/ack/err_clr in; count/busy/last/wrap/done/err out.
module round_seq_ch
    import round_seq_pkg::*;
#(
    parameter int WIDTH   = 7,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 64,
    parameter int STEP    = 1,
    parameter int MODE    = MODE_ONESHOT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             enable,
    input  logic             abort,
    input  logic             ack,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             last,
    output logic             wrap,
    output logic             done,
    output logic             err
);
    localparam logic [WIDTH-1:0] MIN_C  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] STEP_C = WIDTH'(STEP);

    rs_state_t state;
    logic      err_evt;

    // Abort outranks start, so a start swallowed by abort is not an error.
    assign err_evt = !abort && start &&
                     ((state == RS_RUN) || (state == RS_DONE && !ack));

    assign last = (state == RS_RUN) && (count == MAX_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RS_IDLE;
            count <= MIN_C;
            busy  <= 1'b0;
            done  <= 1'b0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            wrap <= 1'b0;

            if (err_evt)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;

            if (abort) begin
                state <= RS_IDLE;
                count <= MIN_C;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                unique case (state)
                    RS_IDLE: begin
                        if (start) begin
                            state <= RS_RUN;
                            count <= MIN_C;
                            busy  <= 1'b1;
                        end
                    end
                    RS_RUN: begin
                        if (enable) begin
                            if (count != MAX_C) begin
                                count <= count + STEP_C;
                            end else if (MODE == MODE_CONTINUOUS) begin
                                count <= MIN_C;
                                wrap  <= 1'b1;
                            end else begin
                                state <= RS_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    RS_DONE: begin
                        if (ack) begin
                            count <= MIN_C;
                            done  <= 1'b0;
                            // start with ack re-arms without an idle cycle
                            if (start) begin
                                state <= RS_RUN;
                                busy  <= 1'b1;
                            end else begin
                                state <= RS_IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= RS_IDLE;
                        count <= MIN_C;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// N_CH independent round counters feeding parallel SHA-256 cores.
// Ports: clk, rst, bus (round_seq_if.slave: start/enable/abort/ack/err_clr in, status out).
module round_sequencer
    import round_seq_pkg::*;
#(
    parameter int WIDTH   = 7,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 64,
    parameter int STEP    = 1,
    parameter int N_CH    = 2,
    parameter int MODE    = MODE_ONESHOT
) (
    input  logic        clk,
    input  logic        rst,
    round_seq_if.slave  bus
);
    if (N_CH < 1) begin : g_bad_nch
        $error("round_sequencer: N_CH must be >= 1");
    end
    if (MAX_VAL >= (1 << WIDTH)) begin : g_bad_width
        $error("round_sequencer: MAX_VAL does not fit in WIDTH");
    end
    if (MAX_VAL <= MIN_VAL) begin : g_bad_range
        $error("round_sequencer: MAX_VAL must exceed MIN_VAL");
    end
    if (STEP < 1) begin : g_bad_step
        $error("round_sequencer: STEP must be >= 1");
    end else if (((MAX_VAL - MIN_VAL) % STEP) != 0) begin : g_bad_align
        $error("round_sequencer: MAX_VAL-MIN_VAL not a multiple of STEP");
    end
    if (MODE != MODE_ONESHOT && MODE != MODE_CONTINUOUS) begin : g_bad_mode
        $error("round_sequencer: unknown MODE");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        round_seq_ch #(
            .WIDTH   (WIDTH),
            .MIN_VAL (MIN_VAL),
            .MAX_VAL (MAX_VAL),
            .STEP    (STEP),
            .MODE    (MODE)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .start   (bus.start[i]),
            .enable  (bus.enable[i]),
            .abort   (bus.abort[i]),
            .ack     (bus.ack[i]),
            .err_clr (bus.err_clr),
            .count   (bus.count[i*WIDTH +: WIDTH]),
            .busy    (bus.busy[i]),
            .last    (bus.last[i]),
            .wrap    (bus.wrap[i]),
            .done    (bus.done[i]),
            .err     (bus.err[i])
        );
    end

endmodule
